// File: rtl/rps_round_judge.sv
// rps_round_judge: runs one rock-paper-scissors round per start request (collect locks, timeout, judge, show).
// Optional build macro ROUND_LIMIT_EN adds a round limit (MAX_ROUNDS) that parks the block in DONE.
module rps_round_judge #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int HOLD_CYCLES    = 4,
   parameter int MAX_ROUNDS     = 9
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [1:0] p1_move,
   input  logic       p1_lock,
   input  logic [1:0] p2_move,
   input  logic       p2_lock,
   output logic [1:0] matchresult,
   output logic       result_valid,
   output logic       busy,
   output logic       timed_out,
   output logic       game_over
);

   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] MV_NONE     = 2'b00;
   localparam logic [1:0] MV_ROCK     = 2'b01;
   localparam logic [1:0] MV_PAPER    = 2'b10;
   localparam logic [1:0] MV_SCISSORS = 2'b11;

   localparam logic [1:0] RES_IDLE = 2'b00;
   localparam logic [1:0] RES_WIN  = 2'b01;
   localparam logic [1:0] RES_LOSE = 2'b11;
   localparam logic [1:0] RES_DRAW = 2'b10;

   if (TIMEOUT_CYCLES < 2 || HOLD_CYCLES < 1 || MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_param_check
      $error("rps_round_judge: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_JUDGE   = 3'd2,
      ST_SHOW    = 3'd3
`ifdef ROUND_LIMIT_EN
      , ST_DONE  = 3'd4
`endif
   } state_t;

   function automatic logic p1_beats(input logic [1:0] m1, input logic [1:0] m2);
      logic win;
      case ({m1, m2})
         {MV_ROCK, MV_SCISSORS},
         {MV_SCISSORS, MV_PAPER},
         {MV_PAPER, MV_ROCK}:     win = 1'b1;
         default:                 win = 1'b0;
      endcase
      return win;
   endfunction

   // A missing lock forfeits the round to whoever did lock; no locks at all is a draw.
   function automatic logic [1:0] judge(input logic l1, input logic l2,
                                        input logic [1:0] m1, input logic [1:0] m2);
      logic [1:0] res;
      case ({l1, l2})
         2'b11: begin
            if (m1 == m2) begin
               res = RES_DRAW;
            end else if (p1_beats(m1, m2)) begin
               res = RES_WIN;
            end else begin
               res = RES_LOSE;
            end
         end
         2'b10:   res = RES_WIN;
         2'b01:   res = RES_LOSE;
         default: res = RES_DRAW;
      endcase
      return res;
   endfunction

   state_t            state_r, state_s;
   logic [1:0]        p1_move_r, p1_move_s, p2_move_r, p2_move_s;
   logic              p1_locked_r, p1_locked_s, p2_locked_r, p2_locked_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [HOLD_W-1:0] hold_r, hold_s;
   logic              to_mark_r, to_mark_s;
   logic [1:0]        matchresult_r, matchresult_s;
   logic              result_valid_r, result_valid_s;
   logic              busy_r, busy_s;
   logic              timed_out_r, timed_out_s;
   logic              p1_take_s, p2_take_s;

   assign p1_take_s = p1_lock && !p1_locked_r && (p1_move != MV_NONE);
   assign p2_take_s = p2_lock && !p2_locked_r && (p2_move != MV_NONE);

`ifdef ROUND_LIMIT_EN
   localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS);
   logic [3:0] round_r, round_s;
   logic       game_over_r;
`endif

   // Next-state, latch and output-register values for the round sequencer.
   always_comb begin
      state_s        = state_r;
      p1_move_s      = p1_move_r;
      p2_move_s      = p2_move_r;
      p1_locked_s    = p1_locked_r;
      p2_locked_s    = p2_locked_r;
      cnt_s          = cnt_r;
      hold_s         = hold_r;
      to_mark_s      = to_mark_r;
      matchresult_s  = matchresult_r;
      result_valid_s = 1'b0;
      timed_out_s    = timed_out_r;
`ifdef ROUND_LIMIT_EN
      round_s        = round_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s     = ST_COLLECT;
               p1_move_s   = MV_NONE;
               p2_move_s   = MV_NONE;
               p1_locked_s = 1'b0;
               p2_locked_s = 1'b0;
               cnt_s       = '0;
               to_mark_s   = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            cnt_s = cnt_r + CNT_W'(1);
            if (p1_take_s) begin
               p1_locked_s = 1'b1;
               p1_move_s   = p1_move;
            end else begin
               p1_locked_s = p1_locked_r;
            end
            if (p2_take_s) begin
               p2_locked_s = 1'b1;
               p2_move_s   = p2_move;
            end else begin
               p2_locked_s = p2_locked_r;
            end
            // Locks arriving on the timeout edge count, so both-locked wins over timeout.
            if (p1_locked_s && p2_locked_s) begin
               state_s   = ST_JUDGE;
               to_mark_s = 1'b0;
            end else if (cnt_r == CNT_LAST) begin
               state_s   = ST_JUDGE;
               to_mark_s = 1'b1;
            end else begin
               state_s = ST_COLLECT;
            end
         end
         ST_JUDGE: begin
            state_s        = ST_SHOW;
            matchresult_s  = judge(p1_locked_r, p2_locked_r, p1_move_r, p2_move_r);
            result_valid_s = 1'b1;
            timed_out_s    = to_mark_r;
            hold_s         = '0;
`ifdef ROUND_LIMIT_EN
            round_s        = round_r + 4'd1;
`endif
         end
         ST_SHOW: begin
            if (hold_r == HOLD_LAST) begin
               matchresult_s = RES_IDLE;
               timed_out_s   = 1'b0;
`ifdef ROUND_LIMIT_EN
               if (round_r == ROUND_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_IDLE;
               end
`else
               state_s = ST_IDLE;
`endif
            end else begin
               hold_s = hold_r + HOLD_W'(1);
            end
         end
`ifdef ROUND_LIMIT_EN
         ST_DONE: begin
            state_s = ST_DONE;
         end
`endif
         default: begin
            state_s       = ST_IDLE;
            matchresult_s = RES_IDLE;
            timed_out_s   = 1'b0;
         end
      endcase
      busy_s = (state_s == ST_COLLECT) || (state_s == ST_JUDGE) || (state_s == ST_SHOW);
   end

   // State, latched moves, counters and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r        <= ST_IDLE;
         p1_move_r      <= MV_NONE;
         p2_move_r      <= MV_NONE;
         p1_locked_r    <= 1'b0;
         p2_locked_r    <= 1'b0;
         cnt_r          <= '0;
         hold_r         <= '0;
         to_mark_r      <= 1'b0;
         matchresult_r  <= RES_IDLE;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         timed_out_r    <= 1'b0;
      end else begin
         state_r        <= state_s;
         p1_move_r      <= p1_move_s;
         p2_move_r      <= p2_move_s;
         p1_locked_r    <= p1_locked_s;
         p2_locked_r    <= p2_locked_s;
         cnt_r          <= cnt_s;
         hold_r         <= hold_s;
         to_mark_r      <= to_mark_s;
         matchresult_r  <= matchresult_s;
         result_valid_r <= result_valid_s;
         busy_r         <= busy_s;
         timed_out_r    <= timed_out_s;
      end
   end

`ifdef ROUND_LIMIT_EN
   // Round count and the sticky game-over flag; only resetn leaves DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         round_r     <= 4'd0;
         game_over_r <= 1'b0;
      end else begin
         round_r     <= round_s;
         game_over_r <= (state_s == ST_DONE);
      end
   end

   assign game_over = game_over_r;
`else
   assign game_over = 1'b0;
`endif

   assign matchresult  = matchresult_r;
   assign result_valid = result_valid_r;
   assign busy         = busy_r;
   assign timed_out    = timed_out_r;

endmodule

// File: tb/tb_rps_round_judge.sv
// Scoreboard bench for rps_round_judge: directed rounds push expected results, a monitor pops on result_valid.
module tb_rps_round_judge;

   localparam int TO   = 8;
   localparam int HOLD = 4;
   localparam int MAXR = 3;
`ifdef ROUND_LIMIT_EN
   localparam bit RST_EACH = 1'b1;
`else
   localparam bit RST_EACH = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [1:0] p1_move = 2'b00;
   logic       p1_lock = 1'b0;
   logic [1:0] p2_move = 2'b00;
   logic       p2_lock = 1'b0;
   logic [1:0] matchresult;
   logic       result_valid;
   logic       busy;
   logic       timed_out;
   logic       game_over;

   rps_round_judge #(
      .TIMEOUT_CYCLES(TO),
      .HOLD_CYCLES   (HOLD),
      .MAX_ROUNDS    (MAXR)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .p1_move     (p1_move),
      .p1_lock     (p1_lock),
      .p2_move     (p2_move),
      .p2_lock     (p2_lock),
      .matchresult (matchresult),
      .result_valid(result_valid),
      .busy        (busy),
      .timed_out   (timed_out),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [1:0] res;
      logic       to;
   } exp_t;

   // k1/j1: COLLECT cycle of p1's first/second lock attempt (-1 = none); jk: cycle whose end edge enters JUDGE.
   typedef struct {
      logic [1:0] a1; int k1; logic [1:0] b1; int j1;
      logic [1:0] a2; int k2; logic [1:0] b2; int j2;
      int         jk;
      logic [1:0] res;
      logic       to;
   } vec_t;

   exp_t q[$];
   vec_t vecs[13];
   int   checks = 0;
   int   failures = 0;
   int   cur = -1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s (round %0d, cycle %0d): actual=%0d required=%0d", name, cur, cyc, act, req);
      end
   endtask

   task automatic monitor();
      int         hold_left = 0;
      logic [1:0] hres = 2'b00;
      logic       hto = 1'b0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            hold_left = 0;
         end else begin
            if (q.size() > 0 && cyc > q[0].cyc) begin
               e = q.pop_front();
               check("missing_valid", 0, 1);
            end
            if (result_valid) begin
               if (q.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("valid_cycle", cyc, e.cyc);
                  check("matchresult", int'(matchresult), int'(e.res));
                  check("timed_out", int'(timed_out), int'(e.to));
                  hold_left = HOLD - 1;
                  hres = e.res;
                  hto = e.to;
               end
            end else if (hold_left > 0) begin
               check("hold_matchresult", int'(matchresult), int'(hres));
               check("hold_timed_out", int'(timed_out), int'(hto));
               hold_left--;
            end else begin
               check("idle_matchresult", int'(matchresult), 0);
               check("idle_timed_out", int'(timed_out), 0);
            end
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_matchresult"}, int'(matchresult), 0);
      check({tag, "_result_valid"}, int'(result_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_timed_out"}, int'(timed_out), 0);
      check({tag, "_game_over"}, int'(game_over), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      resetn = 1'b0;
      start = 1'b0;
      p1_lock = 1'b0;
      p2_lock = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input bit rst_first);
      int   c;
      exp_t e;
      if (rst_first) do_reset();
      @(posedge clk);
      #1;
      c = cyc;
      start = 1'b1;
      e.cyc = c + 3 + v.jk;
      e.res = v.res;
      e.to  = v.to;
      q.push_back(e);
      @(posedge clk);
      #1;
      check("busy_collect", int'(busy), 1);
      for (int k = 0; k <= v.jk; k++) begin
         p1_lock = (k == v.k1) || (k == v.j1);
         p1_move = (k == v.k1) ? v.a1 : ((k == v.j1) ? v.b1 : 2'b00);
         p2_lock = (k == v.k2) || (k == v.j2);
         p2_move = (k == v.k2) ? v.a2 : ((k == v.j2) ? v.b2 : 2'b00);
         @(posedge clk);
         #1;
      end
      p1_lock = 1'b0;
      p2_lock = 1'b0;
      start = 1'b0;
      check("busy_judge", int'(busy), 1);
      repeat (HOLD + 1) @(posedge clk);
      #1;
      check("busy_after_show", int'(busy), 0);
      check("matchresult_after_show", int'(matchresult), 0);
   endtask

   initial begin
      //          a1    k1  b1    j1  a2    k2  b2    j2  jk res   to
      vecs[0]  = '{2'b01, 0, 2'b00, -1, 2'b11, 2, 2'b00, -1, 2, 2'b01, 1'b0}; // rock beats scissors
      vecs[1]  = '{2'b10, 0, 2'b00, -1, 2'b11, 0, 2'b00, -1, 0, 2'b11, 1'b0}; // paper loses to scissors, same cycle
      vecs[2]  = '{2'b10, 1, 2'b00, -1, 2'b10, 1, 2'b00, -1, 1, 2'b10, 1'b0}; // draw, same cycle
      vecs[3]  = '{2'b10, 0, 2'b11,  1, 2'b10, 2, 2'b00, -1, 2, 2'b10, 1'b0}; // p1 relock ignored
      vecs[4]  = '{2'b10, 3, 2'b00, -1, 2'b11, 0, 2'b01,  1, 3, 2'b11, 1'b0}; // p2 relock ignored
      vecs[5]  = '{2'b00,-1, 2'b00, -1, 2'b01, 3, 2'b00, -1, 7, 2'b11, 1'b1}; // timeout, only p2
      vecs[6]  = '{2'b00,-1, 2'b00, -1, 2'b00,-1, 2'b00, -1, 7, 2'b10, 1'b1}; // timeout, nobody
      vecs[7]  = '{2'b11, 1, 2'b00, -1, 2'b10, 7, 2'b00, -1, 7, 2'b01, 1'b0}; // lock on timeout edge
      vecs[8]  = '{2'b00, 0, 2'b11,  2, 2'b01, 1, 2'b00, -1, 2, 2'b11, 1'b0}; // move 00 lock ignored
      vecs[9]  = '{2'b01, 0, 2'b00, -1, 2'b10, 1, 2'b00, -1, 1, 2'b11, 1'b0}; // rock loses to paper
      vecs[10] = '{2'b10, 2, 2'b00, -1, 2'b01, 2, 2'b00, -1, 2, 2'b01, 1'b0}; // paper beats rock
      vecs[11] = '{2'b11, 0, 2'b00, -1, 2'b11, 3, 2'b00, -1, 3, 2'b10, 1'b0}; // scissors draw
      vecs[12] = '{2'b11, 5, 2'b00, -1, 2'b00,-1, 2'b00, -1, 7, 2'b01, 1'b1}; // timeout, only p1

      fork
         monitor();
         begin
            repeat (2) @(posedge clk);
            #1;
            check_all_zero("por");
            @(negedge clk);
            resetn = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 13; i++) begin
               cur = i;
               run_vec(vecs[i], RST_EACH);
            end

            // Reset during the second SHOW cycle abandons the round.
            cur = 100;
            if (RST_EACH) do_reset();
            begin
               int   c;
               exp_t e;
               @(posedge clk);
               #1;
               c = cyc;
               start = 1'b1;
               e.cyc = c + 3;
               e.res = 2'b11;
               e.to  = 1'b0;
               q.push_back(e);
               @(posedge clk);
               #1;
               start = 1'b0;
               p1_lock = 1'b1; p1_move = 2'b01;
               p2_lock = 1'b1; p2_move = 2'b10;
               @(posedge clk);
               #1;
               p1_lock = 1'b0; p2_lock = 1'b0;
               @(posedge clk);
               @(posedge clk);
               #2;
               resetn = 1'b0;
               #1;
               check_all_zero("midshow_reset");
               @(negedge clk);
               resetn = 1'b1;
               @(posedge clk);
               #1;
               check("busy_after_midshow_reset", int'(busy), 0);
            end
            cur = 101;
            run_vec(vecs[0], RST_EACH);

`ifdef ROUND_LIMIT_EN
            cur = 200;
            do_reset();
            run_vec(vecs[0], 1'b0);
            run_vec(vecs[5], 1'b0);
            run_vec(vecs[10], 1'b0);
            check("game_over_after_limit", int'(game_over), 1);
            check("busy_done", int'(busy), 0);
            start = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            start = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check("game_over_held", int'(game_over), 1);
            check("busy_done_after_start", int'(busy), 0);
            check("matchresult_done", int'(matchresult), 0);
            do_reset();
            run_vec(vecs[9], 1'b0);
            check("game_over_new_game", int'(game_over), 0);
`else
            check("game_over_tied_low", int'(game_over), 0);
`endif
            repeat (5) @(posedge clk);
            #1;
            check("queue_empty", q.size(), 0);
         end
         begin
            #50000;
            check("watchdog", 0, 1);
         end
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rps_round_judge.md
Name: rps_round_judge

Overview:
Upstream stage of the score-update block. Runs one rock-paper-scissors round per start request: collects a locked-in move from each player, enforces a timeout and judges the outcome. Presents the result on matchresult with a one-cycle result_valid strobe, which the score-update stage consumes as its round clock and counters.

Parameters:
TIMEOUT_CYCLES, 1000, cycles allowed in COLLECT before the round is forced to judgement (min 2)
HOLD_CYCLES, 4, cycles matchresult is held in SHOW before returning to IDLE (min 1)
MAX_ROUNDS, 9, round limit used only when ROUND_LIMIT_EN is defined (1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request a new round; sampled only in IDLE
p1_move  input  2  player 1 move: 01 rock, 10 paper, 11 scissors, 00 none
p1_lock  input  1  player 1 commits p1_move this cycle
p2_move  input  2  player 2 move, same encoding
p2_lock  input  1  player 2 commits p2_move this cycle
matchresult  output  2  00 idle, 01 p1 win, 11 p1 lose (p2 win), 10 draw
result_valid  output  1  one-cycle pulse on the first SHOW cycle
busy  output  1  high in every state except IDLE (and DONE)
timed_out  output  1  high during SHOW when the round ended by timeout
game_over  output  1  round limit reached (ROUND_LIMIT_EN only, else constant 0)

Behaviour:
- Reset (async, resetn=0): state IDLE; matchresult=00, result_valid=0, busy=0, timed_out=0, game_over=0; latched moves, lock flags, timeout counter and round count cleared. Reset mid-round abandons it with no result emitted.
- IDLE: start=1 -> COLLECT; lock flags and timeout counter cleared on entry. Moves/locks in IDLE ignored.
- COLLECT: a player's first lock with a nonzero move latches that move and sets the player's lock flag. Later locks from that player are ignored. A lock with move 00 is ignored.
- COLLECT: the counter increments every cycle. When both flags are set (including both locking in the same cycle) -> JUDGE on that edge. Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> JUDGE with timeout marked.
- COLLECT, lock on the same edge as the timeout: the lock is accepted before judging.
- JUDGE (1 cycle), both locked: equal moves -> 10. rock>scissors, scissors>paper, paper>rock: p1 winner -> 01, else 11.
- JUDGE, timeout: only p1 locked -> 01; only p2 locked -> 11; neither -> 10.
- JUDGE result is registered on the edge into SHOW.
- SHOW:
  - matchresult stable for exactly HOLD_CYCLES cycles; result_valid=1 only in the first cycle; timed_out reflects the timeout mark.
  - After HOLD_CYCLES -> IDLE, with matchresult=00 and timed_out=0 in the same edge.
- Latency: second lock sampled at edge N -> JUDGE during cycle N..N+1 -> result_valid=1 in the cycle after edge N+1. That is 2 edges from the last lock to the valid result.
- start outside IDLE is ignored; it is not queued.
- matchresult is 00 in every state except SHOW, so downstream gating never sees a spurious win/lose code.
- busy=1 in COLLECT, JUDGE and SHOW.

Optional Feature:
ROUND_LIMIT_EN:
- Defined: an internal 4-bit round count increments on each entry to SHOW. When the SHOW that completes round MAX_ROUNDS exits, the next state is DONE instead of IDLE.
- DONE: game_over=1, busy=0, matchresult=00; start ignored; left only by resetn=0.
- Not defined: no round count and no DONE state; game_over tied to 0; unlimited rounds.

Test Plan:
- Basic win: start; p1 locks 01 (rock), p2 locks 11 (scissors) two cycles later -> result_valid pulses once 2 edges after the p2 lock; matchresult=01 for 4 cycles, then 00; timed_out=0.
- Lose/draw/simultaneous: p1 10, p2 11 locked in the same cycle -> 11. Repeat with both 10 -> 10. Second lock attempts with different moves are ignored and do not change the results.
- Timeout (TIMEOUT_CYCLES=8): p2 locks 01 only -> JUDGE after 8 COLLECT cycles; matchresult=11, timed_out=1. Neither player locks -> 10, timed_out=1.
- Lock/timeout race: p1 already locked; p2 locks on the final COLLECT cycle -> normal judgement with timed_out=0. A p1 lock with move 00 is not accepted.
- Reset mid-SHOW: assert resetn=0 during the 2nd hold cycle -> all outputs 0 immediately; next start begins a fresh round.
- ROUND_LIMIT_EN, MAX_ROUNDS=3: three complete rounds -> game_over=1 after the third SHOW; further start pulses produce no result_valid; resetn clears game_over.
